// File: rtl/native_mem_pkg.sv
// native_mem_pkg: address map, FSM state and region-decode types for native_mem_slave
package native_mem_pkg;
  localparam logic [31:0] GPIO_ADDR   = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h1000_0008;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  typedef enum logic [2:0] {RAM, GPIO, STATUS, CYCLE, UNMAPPED} region_t;
endpackage

// File: rtl/byte_we_ram.sv
// byte_we_ram: single-port word RAM with byte write enables and registered read
module byte_we_ram #(
  parameter int WORDS = 1024,
  parameter string INIT_FILE = "",
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: rtl/native_mem_slave.sv
// native_mem_slave: PicoRV32 native-bus RAM + GPIO/STATUS endpoint with wait states
// Optional MMIO_CYCLE_COUNTER_EN adds a free-running cycle counter at CYCLE_ADDR.
module native_mem_slave
  import native_mem_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out
);
  localparam int AW = $clog2(RAM_WORDS);
  mem_state_t state, state_d;
  region_t region, rsel;
  logic [3:0] cnt, cnt_d;
  logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, word_addr, mmio_rd, mmio_q, ram_q;
  logic [3:0] wstrb_q, cur_wstrb;
  logic commit, unused_ok;
`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cyc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= '0;
    else cyc <= cyc + 32'd1;
`endif
  // With zero wait states the request commits on its acceptance edge, so use the live bus
  always_comb begin
    cur_addr  = state == IDLE ? mem_addr : addr_q;
    cur_wdata = state == IDLE ? mem_wdata : wdata_q;
    cur_wstrb = state == IDLE ? mem_wstrb : wstrb_q;
    word_addr = {cur_addr[31:2], 2'b00};
    commit = mem_valid && ((state == IDLE && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0));
    region = cur_addr[31:AW+2] == '0 ? RAM :
             word_addr == GPIO_ADDR ? GPIO :
             word_addr == STATUS_ADDR ? STATUS :
`ifdef MMIO_CYCLE_COUNTER_EN
             word_addr == CYCLE_ADDR ? CYCLE :
`endif
             UNMAPPED;
    mmio_rd = region == GPIO ? gpio_out :
              region == STATUS ? {28'h0, 4'(WAIT_CYCLES)} :
`ifdef MMIO_CYCLE_COUNTER_EN
              region == CYCLE ? cyc :
`endif
              32'h0;
    state_d = state == IDLE ? (mem_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (!mem_valid ? IDLE : cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_d = state == IDLE ? (WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1)) :
            cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rsel <= UNMAPPED;
      mmio_q <= '0;
      gpio_out <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (state == IDLE && mem_valid) begin
        addr_q <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (commit) begin
        rsel <= region;
        mmio_q <= mmio_rd;
      end
      for (int b = 0; b < 4; b++)
        if (commit && region == GPIO && cur_wstrb[b]) gpio_out[8*b +: 8] <= cur_wdata[8*b +: 8];
    end
  end
  byte_we_ram #(.WORDS(RAM_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk),
    .en(commit && region == RAM),
    .we(cur_wstrb),
    .addr(cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(ram_q)
  );
  assign mem_ready = state == RESP;
  assign mem_rdata = rsel == RAM ? ram_q : mmio_q;
  assign unused_ok = &{1'b0, mem_instr, cur_addr[1:0]};
endmodule

// File: tb/tb_native_mem_slave.sv
// tb_native_mem_slave: directed checks of native_mem_slave with 0 and 3 wait states
module tb_native_mem_slave;
  logic clk = 0, reset_n = 0;
  logic v0 = 0, v3 = 0;
  logic [31:0] a0 = 0, wd0 = 0, a3 = 0, wd3 = 0;
  logic [3:0] ws0 = 0, ws3 = 0;
  logic rdy0, rdy3;
  logic [31:0] rd0, rd3, g0, g3;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;

  native_mem_slave #(.RAM_WORDS(1024), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .mem_valid(v0), .mem_instr(1'b1), .mem_addr(a0),
    .mem_wdata(wd0), .mem_wstrb(ws0), .mem_ready(rdy0), .mem_rdata(rd0), .gpio_out(g0));
  native_mem_slave #(.RAM_WORDS(1024), .WAIT_CYCLES(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .mem_valid(v3), .mem_instr(1'b0), .mem_addr(a3),
    .mem_wdata(wd3), .mem_wstrb(ws3), .mem_ready(rdy3), .mem_rdata(rd3), .gpio_out(g3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one transaction on the 3-wait-state instance; lat is the ready cycle (0 = timed out)
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    v3 = 1; a3 = a; wd3 = wd; ws3 = ws; lat = 0; rd = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (rdy3) begin lat = i; rd = rd3; end
    end
    v3 = 0; ws3 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, c1, c2;
    int l, pulses;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, rdy3}, 32'd0);
    chk("rst_rdata", rd3, 32'd0);
    chk("rst_gpio", g3, 32'd0);
    reset_n = 1;
    // zero wait states: ready the cycle after valid, one cycle wide
    @(negedge clk); v0 = 1; a0 = 32'h0; wd0 = 32'h0000_0093; ws0 = 4'hF;
    @(negedge clk); chk("w0_wr_ready", {31'b0, rdy0}, 32'd1); v0 = 0; ws0 = 0;
    @(negedge clk); chk("w0_wr_drop", {31'b0, rdy0}, 32'd0); v0 = 1;
    @(negedge clk); chk("w0_rd_ready", {31'b0, rdy0}, 32'd1); chk("w0_rd_data", rd0, 32'h93); v0 = 0;
    @(negedge clk); chk("w0_rd_drop", {31'b0, rdy0}, 32'd0); chk("w0_rd_hold", rd0, 32'h93);
    // RAM with byte strobes; writes return the pre-write word
    xact(32'h40, 32'hDEAD_BEEF, 4'hF, r, l); chk("sw_lat", l, 4);
    xact(32'h40, 32'h0, 4'h0, r, l); chk("lw_lat", l, 4); chk("lw_data", r, 32'hDEAD_BEEF);
    xact(32'h40, 32'h11, 4'h1, r, l); chk("sb_prewrite", r, 32'hDEAD_BEEF);
    xact(32'h40, 32'h0, 4'h0, r, l); chk("lw_byte", r, 32'hDEAD_BE11);
    // GPIO
    xact(32'h1000_0000, 32'hA5, 4'hF, r, l); chk("gpio_wr", g3, 32'hA5);
    xact(32'h1000_0000, 32'h0, 4'h0, r, l); chk("gpio_rd", r, 32'hA5);
    xact(32'h1000_0000, 32'hFF00_0000, 4'h8, r, l); chk("gpio_byte", g3, 32'hFF00_00A5);
    // unmapped, read-only and partial-strobe targets still complete
    xact(32'h2000_0000, 32'h0, 4'h0, r, l); chk("unm_lat", l, 4); chk("unm_data", r, 32'h0);
    xact(32'h1000_0004, 32'hFFFF_FFFF, 4'hF, r, l); chk("stat_wr_lat", l, 4);
    xact(32'h1000_0004, 32'h0, 4'h0, r, l); chk("stat_rd", r, 32'h3);
    xact(32'h2000_0000, 32'hAAAA, 4'h2, r, l); chk("unm_part_lat", l, 4);
    chk("unm_gpio_keep", g3, 32'hFF00_00A5);
    // RAM edges: last word, first address past RAM must not alias word 0
    xact(32'h0, 32'h0102_0304, 4'hF, r, l);
    xact(32'hFFC, 32'h5A5A_5A5A, 4'hF, r, l);
    xact(32'hFFC, 32'h0, 4'h0, r, l); chk("ram_last", r, 32'h5A5A_5A5A);
    xact(32'h1000, 32'hFFFF_FFFF, 4'hF, r, l); chk("past_ram_lat", l, 4);
    xact(32'h1000, 32'h0, 4'h0, r, l); chk("past_ram_rd", r, 32'h0);
    xact(32'h0, 32'h0, 4'h0, r, l); chk("no_alias", r, 32'h0102_0304);
    // valid dropped in WAIT aborts without write or ready
    xact(32'h44, 32'h1234_5678, 4'hF, r, l);
    @(negedge clk); v3 = 1; a3 = 32'h44; wd3 = 32'h55; ws3 = 4'hF;
    pulses = 0;
    @(negedge clk); pulses += int'(rdy3);
    @(negedge clk); v3 = 0; ws3 = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); pulses += int'(rdy3); end
    chk("abort_noready", pulses, 0);
    xact(32'h44, 32'h0, 4'h0, r, l); chk("abort_nowrite", r, 32'h1234_5678);
    // reset mid-WAIT loses the pending write, keeps committed RAM
    xact(32'h80, 32'hCAFE_F00D, 4'hF, r, l);
    @(negedge clk); v3 = 1; a3 = 32'h80; wd3 = 32'h1234; ws3 = 4'hF;
    pulses = 0;
    @(negedge clk); pulses += int'(rdy3);
    @(negedge clk); reset_n = 0; v3 = 0; ws3 = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pulses += int'(rdy3); end
    chk("rst_mid_gpio", g3, 32'h0);
    chk("rst_mid_rdata", rd3, 32'h0);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pulses += int'(rdy3); end
    chk("rst_mid_noready", pulses, 0);
    xact(32'h80, 32'h0, 4'h0, r, l); chk("rst_mid_keep", r, 32'hCAFE_F00D);
    // cycle counter reads exactly 10 cycles apart
    xact(32'h1000_0008, 32'h0, 4'h0, c1, l); chk("cyc1_lat", l, 4);
    repeat (5) @(negedge clk);
    xact(32'h1000_0008, 32'h0, 4'h0, c2, l);
`ifdef MMIO_CYCLE_COUNTER_EN
    chk("cyc_delta", c2 - c1, 32'd10);
`else
    chk("cyc_unm1", c1, 32'h0);
    chk("cyc_unm2", c2, 32'h0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
